fifo_read_adapter: RTL and testbench
====================================

// Module: fifo_read_adapter
// PURPOSE
// Consumer-side companion of the synchronous FIFO. It drains the FIFO read port
// (rd_en / data_out / empty / underflow) and re-presents the data as a valid/ready
// stream for downstream logic. It absorbs the FIFO's 1-cycle read latency in a small
// skid buffer, so backpressure never causes a lost or duplicated word.
// It also counts underflow responses, for debug.
// PARAMETERS
// FIFO_WIDTH   16  data width; equals the FIFO's FIFO_WIDTH
// SKID_DEPTH    4  skid buffer entries; legal range 2..16; >=3 for 1 word/cycle sustained
// PORTS
// clk               in   1           system clock, rising edge
// rst_n             in   1           asynchronous, active-low reset
// enable            in   1           1 = adapter may issue FIFO reads
// fifo_data_out     in   FIFO_WIDTH  FIFO read data; valid the cycle after fifo_rd_en
// fifo_empty        in   1           FIFO empty flag
// fifo_underflow    in   1           FIFO flags a read that was rejected (response cycle)
// fifo_rd_en        out  1           read request to the FIFO
// m_data            out  FIFO_WIDTH  stream data = head of skid buffer
// m_valid           out  1           stream valid
// m_ready           in   1           downstream accepts when m_valid && m_ready
// underflow_cnt     out  8           saturating count of underflow responses
// busy              out  1           skid buffer non-empty or a read is in flight
// BEHAVIOUR
// - Reset (async, rst_n=0): count, wr_ptr, rd_ptr, inflight, underflow_cnt, buffer <= 0.
//   Outputs: fifo_rd_en=0, m_valid=0, m_data=0, busy=0. Any in-flight read is discarded.
// - fifo_rd_en (combinational) = enable && !fifo_empty && (count + inflight) < SKID_DEPTH.
//   It has no combinational path from m_ready; the pop credit is deliberately not used.
// - inflight: 1-bit register, inflight <= fifo_rd_en.
// - Response cycle (inflight=1):
//   - fifo_underflow=0: push fifo_data_out at wr_ptr; wr_ptr wraps modulo SKID_DEPTH.
//   - fifo_underflow=1: no push; underflow_cnt++, saturating at 255 (holds).
//   - fifo_underflow while inflight=0 is ignored.
// - Stream side:
//   - m_valid = (count != 0); m_data = buf[rd_ptr].
//   - Pop on m_valid && m_ready; rd_ptr wraps modulo SKID_DEPTH.
//   - m_data holds stable while m_valid && !m_ready.
// - Same-cycle push and pop: count unchanged, both pointers advance. Push alone: +1. Pop alone: -1.
// - The credit rule guarantees no push is ever issued into a full buffer.
//   Overflow of the skid buffer is a design error; assert on it.
// - Latency: fifo_rd_en high in cycle N -> word captured at end of N+1 -> m_valid by N+2.
// - Throughput: with m_ready=1, FIFO non-empty and SKID_DEPTH>=3, 1 word/cycle sustained.
// - enable deasserted: no new reads; the in-flight word is still captured; buffered words still drain.
// - busy = (count != 0) || inflight.
// - Ordering: words leave on m_data in exactly the FIFO read order. No drop, no duplicate.
// TESTING
// 1 Assert rst_n=0 with garbage inputs -> all outputs 0; release -> stay 0 while fifo_empty=1.
// 2 FIFO model holds 0x0001..0x0008, enable=1, m_ready=1 ->
//   m_data 0x0001..0x0008 on consecutive cycles, first m_valid 2 cycles after first rd_en.
// 3 As test 2 with m_ready=0 -> exactly 4 rd_en pulses; m_valid=1, m_data=0x0001 held.
//   Then m_ready=1 -> 0x0001..0x0008 in order, no gaps after the refill.
// 4 Model answers one read with fifo_underflow=1 -> no word emitted for it, underflow_cnt=1.
//   300 forced underflows -> underflow_cnt=255.
// 5 enable drops the cycle after a rd_en -> the in-flight word is still delivered.
//   No further rd_en; busy falls to 0 once the buffer drains.
// 6 rst_n pulsed low mid-stream with count=3 -> m_valid=0 and busy=0 immediately (async).
//   After release, reading resumes from the FIFO model's current head.

Source files
------------

// File: rtl/fifo_read_adapter.sv
// Drains a synchronous FIFO read port into a valid/ready stream through a skid
// buffer sized to absorb the FIFO's one-cycle read latency; counts underflow responses.
module fifo_read_adapter #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned SKID_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [7:0]            underflow_cnt,
   output logic                  busy
);

   localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SKID_DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(SKID_DEPTH);
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(SKID_DEPTH);

   logic [FIFO_WIDTH-1:0] skid_q [SKID_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  inflight;
   logic                  push;
   logic                  pop;
   logic [OCC_W-1:0]      occupancy;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit counts the in-flight read so a response always finds a free slot.
   assign occupancy  = OCC_W'(count) + OCC_W'(inflight);
   assign fifo_rd_en = rst_n && enable && !fifo_empty && (occupancy < DEPTH_OCC);

   assign push    = inflight && !fifo_underflow;
   assign m_valid = (count != '0);
   assign pop     = m_valid && m_ready;
   assign m_data  = skid_q[rd_ptr];
   assign busy    = m_valid || inflight;

   // Skid buffer storage, pointers, occupancy and the read-in-flight flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(SKID_DEPTH); i++) begin
            skid_q[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         if (push) begin
            skid_q[wr_ptr] <= fifo_data_out;
            wr_ptr         <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Debug counter of rejected reads; saturates rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underflow_cnt <= '0;
      end else if (inflight && fifo_underflow && (underflow_cnt != 8'hFF)) begin
         underflow_cnt <= underflow_cnt + 8'd1;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (count == DEPTH_CNT)))
      else $error("skid buffer overflow");

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Bench for fifo_read_adapter: reset/idle vector table, directed corner sequences and
// randomized traffic checked against a queue-based model of the FIFO and the stream.
module tb_fifo_read_adapter;

   localparam int unsigned W     = 16;
   localparam int unsigned DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic [W-1:0] fifo_data_out;
   logic         fifo_empty;
   logic         fifo_underflow;
   logic         fifo_rd_en;
   logic [W-1:0] m_data;
   logic         m_valid;
   logic         m_ready;
   logic [7:0]   underflow_cnt;
   logic         busy;

   fifo_read_adapter #(.FIFO_WIDTH(W), .SKID_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .fifo_data_out  (fifo_data_out),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .fifo_rd_en     (fifo_rd_en),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .underflow_cnt  (underflow_cnt),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rst_n;
      logic         enable;
      logic         fifo_empty;
      logic         m_ready;
      logic         exp_rd_en;
      logic         exp_m_valid;
      logic         exp_busy;
      logic [W-1:0] exp_m_data;
   } vec_t;

   vec_t vecs [6];

   // Reference model: FIFO contents, words owed to the stream, pending read response.
   logic [W-1:0] fq [$];
   logic [W-1:0] exp_q [$];
   logic         last_rd;
   logic         resp_uf;
   logic [W-1:0] resp_word;
   int           force_uf;
   int           ucnt;

   int vectors;
   int miscompares;
   int cyc;
   int dut_rd;
   int dut_beats;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check 1 time unit later, then advance the model.
   task automatic step(input logic en, input logic rdy);
      logic exp_rd;
      @(negedge clk);
      cyc++;
      enable     = en;
      m_ready    = rdy;
      fifo_empty = (fq.size() == 0);
      if (last_rd) begin
         fifo_data_out  = resp_uf ? W'($urandom) : resp_word;
         fifo_underflow = resp_uf;
      end else begin
         fifo_data_out  = W'($urandom);
         fifo_underflow = 1'($urandom);
      end
      exp_rd = en && (fq.size() != 0) && ((exp_q.size() + int'(last_rd)) < int'(DEPTH));
      #1;
      chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
      chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      chk("busy", 32'(busy), 32'((exp_q.size() != 0) || last_rd));
      chk("underflow_cnt", 32'(underflow_cnt), 32'(ucnt));
      if (exp_q.size() != 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
      if (fifo_rd_en) dut_rd++;
      if (m_valid && m_ready) dut_beats++;
      if ((exp_q.size() != 0) && rdy) void'(exp_q.pop_front());
      if (last_rd) begin
         if (resp_uf) begin
            if (ucnt < 255) ucnt++;
         end else begin
            exp_q.push_back(resp_word);
         end
      end
      last_rd = exp_rd;
      if (exp_rd) begin
         if (force_uf > 0) begin
            resp_uf = 1'b1;
            force_uf--;
         end else begin
            resp_uf   = 1'b0;
            resp_word = fq.pop_front();
         end
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 64 && ((exp_q.size() != 0) || last_rd); k++) step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("drain_busy", 32'(busy), 32'd0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      last_rd = 1'b0;
      resp_uf = 1'b0;
      ucnt    = 0;
   endtask

   initial begin
      int first_rd;
      int first_v;
      logic [W-1:0] first_word;

      vectors = 0; miscompares = 0; cyc = 0; force_uf = 0;
      enable = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
      fifo_data_out = '0; fifo_underflow = 1'b0;
      model_reset();

      //              rst en emp rdy  rd v  bsy data
      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};

      rst_n = 1'b1;
      #2 rst_n = 1'b0;

      // Reset and idle behaviour with garbage on the data/underflow inputs.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cyc++;
         rst_n          = vecs[i].rst_n;
         enable         = vecs[i].enable;
         fifo_empty     = vecs[i].fifo_empty;
         m_ready        = vecs[i].m_ready;
         fifo_data_out  = W'($urandom);
         fifo_underflow = 1'($urandom);
         #1;
         chk($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].exp_rd_en));
         chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].exp_m_valid));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].exp_m_data));
         chk($sformatf("vec%0d_ucnt", i), 32'(underflow_cnt), 32'd0);
      end
      @(negedge clk);
      enable = 1'b0; fifo_empty = 1'b1; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Streaming at full rate, checking first-beat latency.
      for (int w = 1; w <= 8; w++) fq.push_back(W'(w));
      first_rd = -1; first_v = -1;
      for (int c = 0; c < 14; c++) begin
         step(1'b1, 1'b1);
         if (fifo_rd_en && first_rd < 0) first_rd = c;
         if (m_valid && first_v < 0) first_v = c;
      end
      chk("first_valid_latency", 32'(first_v - first_rd), 32'd2);
      drain();

      // Backpressure: exactly DEPTH reads, head held, then drains in order.
      for (int w = 1; w <= 8; w++) fq.push_back(W'(w));
      dut_rd = 0;
      for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
      chk("bp_rd_pulses", 32'(dut_rd), 32'(DEPTH));
      chk("bp_head_word", 32'(m_data), 32'h0001);
      dut_beats = 0;
      for (int c = 0; c < 14; c++) step(1'b1, 1'b1);
      drain();
      chk("bp_total_beats", 32'(dut_beats), 32'd8);

      // Single underflow response, then saturation.
      fq.push_back(16'h00A1); fq.push_back(16'h00A2);
      force_uf = 1;
      for (int c = 0; c < 6; c++) step(1'b1, 1'b1);
      chk("ucnt_one", 32'(underflow_cnt), 32'd1);
      drain();
      fq.push_back(16'h00A3);
      force_uf = 300;
      for (int c = 0; c < 400 && force_uf > 0; c++) step(1'b1, 1'b1);
      chk("uf_loop_bound", 32'(force_uf), 32'd0);
      drain();
      chk("ucnt_sat", 32'(underflow_cnt), 32'd255);

      // enable drops right after one read: that word still arrives, nothing else issued.
      fq.delete();
      for (int w = 0; w < 4; w++) fq.push_back(16'h00B1 + W'(w));
      step(1'b1, 1'b1);
      dut_rd = 0; dut_beats = 0;
      for (int c = 0; c < 6; c++) step(1'b0, 1'b1);
      chk("en_drop_rd_pulses", 32'(dut_rd), 32'd0);
      chk("en_drop_beats", 32'(dut_beats), 32'd1);
      chk("en_drop_busy", 32'(busy), 32'd0);

      // Asynchronous reset mid-stream with three words buffered.
      fq.delete();
      for (int w = 0; w < 8; w++) fq.push_back(16'h00C1 + W'(w));
      for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
      for (int c = 0; c < 2; c++) step(1'b0, 1'b0);
      chk("pre_reset_count", 32'(exp_q.size()), 32'd3);
      @(negedge clk);
      cyc++;
      enable = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("async_rst_m_valid", 32'(m_valid), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_ucnt", 32'(underflow_cnt), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      first_word = '0;
      first_v    = -1;
      for (int c = 0; c < 12; c++) begin
         step(1'b1, 1'b1);
         if (m_valid && first_v < 0) begin
            first_v    = c;
            first_word = m_data;
         end
      end
      chk("resume_head", 32'(first_word), 32'h00C4);
      drain();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0 && fq.size() < 20) begin
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) fq.push_back(W'($urandom));
         end
         if ($urandom_range(0, 31) == 0) force_uf++;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
      force_uf = 0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
